// File: rtl/audio_pkg.sv
// Shared audio definitions for the pedal-board signal chain (tremolo, I2S DAC
// serializer, future ADC deserializer).
//   SAMPLE_W      bits per audio sample, two's complement
//   sample_t      signed sample type
//   DEF_SLOT_W    default BCLK periods per I2S channel slot
//   DEF_CLK_DIV   default system clocks per BCLK half-period
package audio_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int DEF_SLOT_W  = 32;
   localparam int DEF_CLK_DIV = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator. Divides the system clock down to BCLK and flags the
// system-clock cycle whose closing edge takes BCLK from 1 to 0.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   bclk      registered bit clock, CLK_DIV clk cycles per half-period
//   fall_evt  high in the cycle whose closing clk edge drives bclk 1->0
module i2s_clk_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic bclk,
   output logic fall_evt
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             wrap;

   assign wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign fall_evt = wrap & bclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_dac_serializer.sv
// Master-mode I2S serializer feeding the codec DAC. One mono sample is latched
// per frame and sent MSB first in both the left and right slots, with the
// standard one-BCLK delay after each word-select transition. Remaining slot
// bits are driven 0.
//   CLK          system clock
//   RESET        asynchronous active-low reset
//   Signal_in    sample from the effect chain, captured at frame start
//   sample_req   one-CLK pulse in the cycle after Signal_in was latched
//   AUD_BCLK     I2S bit clock
//   AUD_DACLRCK  word select, 0 = left slot, 1 = right slot
//   AUD_DACDAT   serial data, changes only when BCLK falls
module i2s_dac_serializer
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
   parameter int SLOT_W   = DEF_SLOT_W,
   parameter int CLK_DIV  = DEF_CLK_DIV
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic signed [SAMPLE_W-1:0] Signal_in,
   output logic                       sample_req,
   output logic                       AUD_BCLK,
   output logic                       AUD_DACLRCK,
   output logic                       AUD_DACDAT
);

   localparam int FRAME_BITS = 2 * SLOT_W;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int IDX_W      = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

   if (SAMPLE_W > SLOT_W - 1) begin : g_bad_sample_w
      $error("i2s_dac_serializer: SAMPLE_W must be <= SLOT_W-1");
   end
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("i2s_dac_serializer: CLK_DIV must be >= 2");
   end

   logic                       bclk;
   logic                       fall_evt;
   logic [BIT_W-1:0]           bit_cnt;
   logic [BIT_W-1:0]           bit_nxt;
   logic [BIT_W-1:0]           pos_nxt;
   logic [IDX_W-1:0]           idx;
   logic                       frame_wrap;
   logic                       lrck_nxt;
   logic                       data_nxt;
   logic signed [SAMPLE_W-1:0] sample_q;

   i2s_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (CLK),
      .rst_n    (RESET),
      .bclk     (bclk),
      .fall_evt (fall_evt)
   );

   assign AUD_BCLK = bclk;

   // Everything below looks one bit ahead: the values are those the outputs
   // take at the coming fall event, so data lags word select by one BCLK.
   always_comb begin
      frame_wrap = (bit_cnt == BIT_W'(FRAME_BITS - 1));
      bit_nxt    = frame_wrap ? '0 : bit_cnt + 1'b1;
      lrck_nxt   = (bit_nxt >= BIT_W'(SLOT_W));
      pos_nxt    = lrck_nxt ? bit_nxt - BIT_W'(SLOT_W) : bit_nxt;
      idx        = IDX_W'(BIT_W'(SAMPLE_W) - pos_nxt);
      data_nxt   = 1'b0;
      if (pos_nxt != '0 && pos_nxt <= BIT_W'(SAMPLE_W)) begin
         data_nxt = sample_q[idx];
      end
   end

   // At the frame wrap the next slot position is 0, so data_nxt never reads
   // sample_q in the same cycle it is reloaded.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         bit_cnt     <= '0;
         AUD_DACLRCK <= 1'b0;
         AUD_DACDAT  <= 1'b0;
         sample_req  <= 1'b0;
         sample_q    <= '0;
      end else begin
         sample_req <= 1'b0;
         if (fall_evt) begin
            bit_cnt     <= bit_nxt;
            AUD_DACLRCK <= lrck_nxt;
            AUD_DACDAT  <= data_nxt;
            if (frame_wrap) begin
               sample_q   <= Signal_in;
               sample_req <= 1'b1;
            end
         end
      end
   end

endmodule
